// File: rtl/shared_ram_pkg.sv
// Purpose : shared definitions for the multi-core shared RAM.
// Contents: controller FSM state encoding.
package shared_ram_pkg;

    // INIT clears the array after reset; RUN serves core requests.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/shared_ram_if.sv
// Purpose : request/response bundle between the cores and the shared RAM.
// Signals : req/wrEn/addr/dataIn per core (core -> RAM),
//           gnt/rdValid per core, shared dataOut, ready (RAM -> cores).
interface shared_ram_if #(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned PORTS      = 4
);
    logic [PORTS-1:0]                 req;
    logic [PORTS-1:0]                 wrEn;
    logic [PORTS-1:0][ADDR_WIDTH-1:0] addr;
    logic [PORTS-1:0][WIDTH-1:0]      dataIn;
    logic [PORTS-1:0]                 gnt;
    logic [PORTS-1:0]                 rdValid;
    logic [WIDTH-1:0]                 dataOut;
    logic                             ready;

    modport master (
        output req, wrEn, addr, dataIn,
        input  gnt, rdValid, dataOut, ready
    );

    modport slave (
        input  req, wrEn, addr, dataIn,
        output gnt, rdValid, dataOut, ready
    );
endinterface

// File: rtl/shared_ram_rr_arbiter.sv
// Purpose : round-robin arbiter, one grant per cycle, combinational grant.
// Ports   : clk, rst (async active-high), req[PORTS], en (arbitration enable),
//           gnt[PORTS] one-hot-or-zero.
module rr_arbiter
    import shared_ram_pkg::*;
#(
    parameter int unsigned PORTS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] req,
    input  logic             en,
    output logic [PORTS-1:0] gnt
);

    localparam int unsigned PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_nxt_ptr;
    logic [SUM_W-1:0] w_idx;
    logic             w_found;

    // Scan cores starting at r_ptr (highest priority), wrapping at PORTS.
    always_comb begin
        gnt       = '0;
        w_nxt_ptr = r_ptr;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            w_idx = {1'b0, r_ptr} + SUM_W'(i);
            if (w_idx >= SUM_W'(PORTS)) begin
                w_idx = w_idx - SUM_W'(PORTS);
            end
            if (en && !w_found && req[w_idx[PTR_W-1:0]]) begin
                gnt[w_idx[PTR_W-1:0]] = 1'b1;
                w_found               = 1'b1;
                w_nxt_ptr = (w_idx == SUM_W'(PORTS - 1)) ? '0 : PTR_W'(w_idx + 1'b1);
            end
        end
    end

    // Priority moves past the winner only when something was granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (|gnt) begin
            r_ptr <= w_nxt_ptr;
        end
    end

endmodule

// File: rtl/shared_ram.sv
// Purpose : single-port RAM shared by PORTS cores through a round-robin
//           arbiter; cleared to zero after every reset before serving.
// Ports   : clk, rst (async active-high), bus (shared_ram_if slave):
//           req/wrEn/addr/dataIn in, gnt (comb), rdValid/dataOut (1-cycle
//           read latency), ready (clear finished).
module shared_ram
    import shared_ram_pkg::*;
#(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned PORTS      = 4
) (
    input  logic         clk,
    input  logic         rst,
    shared_ram_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(PORTS);
    localparam int unsigned CLR_W = ADDR_WIDTH + 1;

    state_t                  r_state;
    logic [CLR_W-1:0]        r_clr_ptr;
    logic                    r_ready;
    logic [WIDTH-1:0]        r_mem [DEPTH];
    logic [WIDTH-1:0]        r_data_out;
    logic [PORTS-1:0]        r_rd_valid;

    logic                    w_run;
    logic [PORTS-1:0]        w_gnt;
    logic [PTR_W-1:0]        w_gidx;
    logic                    w_any;
    logic                    w_g_wr;
    logic [ADDR_WIDTH-1:0]   w_g_addr;
    logic [WIDTH-1:0]        w_g_data;
    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [WIDTH-1:0]        w_mem_wdata;

    // Fold addresses >= DEPTH back into range (only matters for non-pow2 DEPTH).
    function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH-1:0] a);
        logic [CLR_W-1:0] ext;
        ext = {1'b0, a};
        if (ext >= CLR_W'(DEPTH)) begin
            return ADDR_WIDTH'(ext - CLR_W'(DEPTH));
        end
        return a;
    endfunction

    assign w_run = (r_state == RUN);

    rr_arbiter #(.PORTS(PORTS)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (bus.req),
        .en  (w_run),
        .gnt (w_gnt)
    );

    // Encode the one-hot grant and pick up the winner's request fields.
    always_comb begin
        w_gidx = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (w_gnt[i]) begin
                w_gidx = PTR_W'(i);
            end
        end
    end

    assign w_any    = |w_gnt;
    assign w_g_wr   = w_any & bus.wrEn[w_gidx];
    assign w_g_addr = wrap_addr(bus.addr[w_gidx]);
    assign w_g_data = bus.dataIn[w_gidx];

    // One write port shared between the clear sweep and granted writes.
    assign w_mem_we    = w_run ? w_g_wr : 1'b1;
    assign w_mem_addr  = w_run ? w_g_addr : r_clr_ptr[ADDR_WIDTH-1:0];
    assign w_mem_wdata = w_run ? w_g_data : '0;

    // Controller: sweep clear in INIT, then serve requests in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= INIT;
            r_clr_ptr <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    if (r_clr_ptr == CLR_W'(DEPTH - 1)) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + 1'b1;
                    end
                end
                RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Registered read port; dataOut holds across write/idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= '0;
            r_data_out <= '0;
        end else begin
            r_rd_valid <= '0;
            if (w_any && !w_g_wr) begin
                r_rd_valid <= w_gnt;
                r_data_out <= r_mem[w_g_addr];
            end
        end
    end

    assign bus.gnt     = w_gnt;
    assign bus.rdValid = r_rd_valid;
    assign bus.dataOut = r_data_out;
    assign bus.ready   = r_ready;

endmodule

// File: tb/tb_shared_ram.sv
// Purpose : directed self-checking bench for shared_ram (PORTS=4, WIDTH=12,
//           DEPTH=256): clear latency, single core, fairness, contention,
//           reset mid-clear and reset during a read.
module tb_shared_ram;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned PORTS = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    shared_ram_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS)) bus ();

    shared_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req    = '0;
        bus.wrEn   = '0;
        bus.addr   = '0;
        bus.dataIn = '0;
    endtask

    task automatic set_core(input int c, input logic we, input logic [7:0] a, input logic [11:0] d);
        bus.req[c]    = 1'b1;
        bus.wrEn[c]   = we;
        bus.addr[c]   = a;
        bus.dataIn[c] = d;
    endtask

    // Count edges until ready, watching for illegal grants or read strobes.
    task automatic wait_ready(output int cyc, output logic saw_gnt, output logic saw_rdv);
        cyc     = 0;
        saw_gnt = 1'b0;
        saw_rdv = 1'b0;
        while (bus.ready !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
            if (bus.ready !== 1'b1 && bus.gnt !== 4'b0000) saw_gnt = 1'b1;
            if (bus.rdValid !== 4'b0000) saw_rdv = 1'b1;
        end
    endtask

    initial begin
        int          cyc;
        logic        sg;
        logic        sr;
        logic [11:0] exp_d [4];

        // Reset state
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        chk("rst_ready",   32'(bus.ready),   32'h0);
        chk("rst_gnt",     32'(bus.gnt),     32'h0);
        chk("rst_rdvalid", 32'(bus.rdValid), 32'h0);
        chk("rst_dout",    32'(bus.dataOut), 32'h0);

        // Core 0 requests a read of 0x7F during the clear; must wait, not be lost
        set_core(0, 1'b0, 8'h7F, 12'h000);
        rst = 1'b0;
        wait_ready(cyc, sg, sr);
        chk("init_latency", 32'(cyc), 32'd256);
        chk("init_no_gnt",  32'(sg),  32'h0);
        chk("held_req_gnt", 32'(bus.gnt), 32'b0001);
        tick();
        chk("rd7f_valid", 32'(bus.rdValid), 32'b0001);
        chk("rd7f_data",  32'(bus.dataOut), 32'h000);
        idle_inputs();
        #1;
        chk("idle_gnt", 32'(bus.gnt), 32'h0);
        tick();
        chk("idle_rdvalid", 32'(bus.rdValid), 32'h0);

        // Single core: write then read; core 0 drives garbage without req
        set_core(2, 1'b1, 8'h10, 12'hABC);
        bus.wrEn[0]   = 1'b1;
        bus.addr[0]   = 8'h10;
        bus.dataIn[0] = 12'hFFF;
        #1;
        chk("sc_wr_gnt", 32'(bus.gnt), 32'b0100);
        tick();
        chk("sc_wr_rdvalid", 32'(bus.rdValid), 32'h0);
        bus.wrEn[2] = 1'b0;
        #1;
        chk("sc_rd_gnt", 32'(bus.gnt), 32'b0100);
        tick();
        chk("sc_rd_valid", 32'(bus.rdValid), 32'b0100);
        chk("sc_rd_data",  32'(bus.dataOut), 32'hABC);
        idle_inputs();

        // Core 3 write so the priority pointer sits at core 0
        set_core(3, 1'b1, 8'h30, 12'h055);
        #1;
        chk("prep_gnt", 32'(bus.gnt), 32'b1000);
        tick();
        idle_inputs();

        // Fairness: all four read for 8 cycles
        set_core(0, 1'b0, 8'h10, 12'h000);
        set_core(1, 1'b0, 8'h7F, 12'h000);
        set_core(2, 1'b0, 8'h30, 12'h000);
        set_core(3, 1'b0, 8'h10, 12'h000);
        exp_d[0] = 12'hABC;
        exp_d[1] = 12'h000;
        exp_d[2] = 12'h055;
        exp_d[3] = 12'hABC;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                chk("fair_rdvalid", 32'(bus.rdValid), 32'(1 << ((k - 1) % 4)));
                chk("fair_data",    32'(bus.dataOut), 32'(exp_d[(k - 1) % 4]));
            end
            chk("fair_gnt", 32'(bus.gnt), 32'(1 << (k % 4)));
            tick();
        end
        chk("fair_last_rdvalid", 32'(bus.rdValid), 32'b1000);
        chk("fair_last_data",    32'(bus.dataOut), 32'hABC);
        idle_inputs();

        // Contention: cores 1 and 3 write the same address
        set_core(1, 1'b1, 8'h20, 12'h111);
        set_core(3, 1'b1, 8'h20, 12'h333);
        #1;
        chk("cont_gnt_first", 32'(bus.gnt), 32'b0010);
        tick();
        bus.req[1] = 1'b0;
        #1;
        chk("cont_gnt_second", 32'(bus.gnt), 32'b1000);
        tick();
        idle_inputs();
        set_core(0, 1'b0, 8'h20, 12'h000);
        #1;
        chk("cont_rd_gnt", 32'(bus.gnt), 32'b0001);
        tick();
        chk("cont_rdvalid", 32'(bus.rdValid), 32'b0001);
        chk("cont_data",    32'(bus.dataOut), 32'h333);
        idle_inputs();

        // Reset mid-clear at clear cycle 100
        rst = 1'b1;
        #1;
        chk("rst2_dout",  32'(bus.dataOut), 32'h0);
        chk("rst2_ready", 32'(bus.ready),   32'h0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        chk("midclr_ready", 32'(bus.ready), 32'h0);
        rst = 1'b1;
        #1;
        chk("midclr_ready_rst", 32'(bus.ready), 32'h0);
        tick();
        rst = 1'b0;
        wait_ready(cyc, sg, sr);
        chk("reclr_latency", 32'(cyc), 32'd256);

        // Post-clear: write, read back, and confirm earlier data was wiped
        set_core(0, 1'b1, 8'h40, 12'h7AB);
        #1;
        chk("post_wr_gnt", 32'(bus.gnt), 32'b0001);
        tick();
        bus.wrEn[0] = 1'b0;
        tick();
        chk("post_rd_valid", 32'(bus.rdValid), 32'b0001);
        chk("post_rd_data",  32'(bus.dataOut), 32'h7AB);
        bus.addr[0] = 8'h20;
        tick();
        chk("cleared_valid", 32'(bus.rdValid), 32'b0001);
        chk("cleared_data",  32'(bus.dataOut), 32'h000);

        // Reset while a read is in flight
        bus.addr[0] = 8'h40;
        #1;
        chk("rdrst_gnt", 32'(bus.gnt), 32'b0001);
        #1;
        rst = 1'b1;
        #1;
        chk("rdrst_valid", 32'(bus.rdValid), 32'h0);
        chk("rdrst_dout",  32'(bus.dataOut), 32'h0);
        tick();
        chk("rdrst_valid_edge", 32'(bus.rdValid), 32'h0);
        chk("rdrst_dout_edge",  32'(bus.dataOut), 32'h0);
        idle_inputs();
        rst = 1'b0;
        wait_ready(cyc, sg, sr);
        chk("rdrst_no_rdvalid", 32'(sr),  32'h0);
        chk("rdrst_latency",    32'(cyc), 32'd256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_ram.md
SHARED_RAM -- requirements
Module: shared_ram

Interface
REQ-001 SHALL have parameter WIDTH, default 12, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, number of words.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), address width.
REQ-004 SHALL have parameter PORTS, default 4, number of requesting cores (>=2).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req  input  [PORTS]  per-core access request.
REQ-008 SHALL have port wrEn  input  [PORTS]  per-core write (1) / read (0) qualifier, sampled only with req.
REQ-009 SHALL have port addr  input  [PORTS][ADDR_WIDTH]  per-core word address.
REQ-010 SHALL have port dataIn  input  [PORTS][WIDTH]  per-core write data.
REQ-011 SHALL have port gnt  output  [PORTS]  one-hot-or-zero grant, combinational, same cycle as req.
REQ-012 SHALL have port rdValid  output  [PORTS]  one-hot-or-zero, marks dataOut valid for that core.
REQ-013 SHALL have port dataOut  output  WIDTH  shared read data bus.
REQ-014 SHALL have port ready  output  1  high once post-reset clear completes.

Function
REQ-015 SHALL implement a two-state FSM: INIT (clear memory) and RUN (serve requests).
REQ-016 SHALL, in INIT, write zero to address clrPtr each cycle, clrPtr counting 0..DEPTH-1, then enter RUN on the cycle after writing DEPTH-1.
REQ-017 SHALL hold gnt=0 and ready=0 throughout INIT; requests during INIT are neither granted nor lost (core keeps req high).
REQ-018 SHALL, in RUN, grant at most one core per cycle using round-robin priority starting from the core after the last granted core.
REQ-019 SHALL, when only one core requests, grant it immediately regardless of priority pointer.
REQ-020 SHALL advance the priority pointer only on a cycle with a grant; idle cycles leave it unchanged.
REQ-021 SHALL, on a granted write, store dataIn[g] at addr[g] at the clock edge ending the grant cycle.
REQ-022 SHALL, on a granted read, drive dataOut with memory[addr[g]] and rdValid[g]=1 exactly one cycle after the grant (latency 1).
REQ-023 SHALL hold dataOut at its last read value and rdValid=0 in cycles following a write or idle grant cycle.
REQ-024 SHALL return, for a read granted the cycle after a write to the same address, the newly written data.
REQ-025 SHALL wrap address arithmetic modulo DEPTH; clrPtr SHALL be ADDR_WIDTH+1 bits to detect terminal count for non-power-of-2 DEPTH.
REQ-026 SHALL ignore wrEn, addr, dataIn of non-granted cores.

Reset
REQ-027 SHALL, on rst assertion at any time (including mid-clear or mid-read), asynchronously force state=INIT, clrPtr=0, priority pointer=core 0, gnt=0, rdValid=0, dataOut=0, ready=0.
REQ-028 SHALL restart the full clear sequence after every reset deassertion; a read in flight at reset SHALL produce no rdValid.

Structure
REQ-029 SHALL place the FSM state enum (INIT, RUN) in package shared_ram_pkg.
REQ-030 SHALL implement arbitration in sub-module rr_arbiter (parameter PORTS; inputs clk, rst, req, en; output gnt), en tied to RUN state.
REQ-031 SHALL keep the memory array single-write-port, single-read-port, inferable as block RAM.

Verification (PORTS=4, WIDTH=12, DEPTH=256)
REQ-032 SHALL check reset then idle: ready rises exactly 256 cycles after rst deasserts; reading addr 0x7F then returns 0x000.
REQ-033 SHALL check single core: core 2 writes 0xABC to 0x10, next cycle reads 0x10 -> gnt[2] both cycles, rdValid[2]=1 and dataOut=0xABC one cycle after read grant.
REQ-034 SHALL check fairness: all four req held high for 8 cycles of reads -> grants in order 0,1,2,3,0,1,2,3, each rdValid one cycle later.
REQ-035 SHALL check contention: cores 1 and 3 write 0x111 and 0x333 to address 0x20 simultaneously -> core 1 granted first, core 3 next; read of 0x20 returns 0x333.
REQ-036 SHALL check reset mid-clear: rst pulsed at clear cycle 100 -> ready stays low, clear restarts at 0, ready rises 256 cycles after second deassertion.
REQ-037 SHALL check reset during read: read granted, rst asserted before next edge -> rdValid never asserts, dataOut=0.
